// File: rtl/branch_resolve.sv
// EX-stage branch resolution: evaluates the control-transfer condition,
// produces the next PC, flags mispredictions, holds an IF/ID flush window
// and keeps saturating branch / mispredict statistics.
module branch_resolve #(
    parameter int unsigned WIDTH_PC     = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_ex,
    input  logic                 stall_ex,
    input  logic                 is_branch,
    input  logic                 is_jal,
    input  logic                 is_jalr,
    input  logic [2:0]           funct3,
    input  logic [WIDTH_PC-1:0]  rs1_data,
    input  logic [WIDTH_PC-1:0]  rs2_data,
    input  logic [WIDTH_PC-1:0]  imm,
    input  logic [WIDTH_PC-1:0]  pc_ex,
    input  logic                 pred_taken,
    output logic                 PCSel,
    output logic [WIDTH_PC-1:0]  branch_pc,
    output logic                 mispredict,
    output logic                 flush_IF_ID,
    output logic [CNT_WIDTH-1:0] branch_cnt,
    output logic [CNT_WIDTH-1:0] mispred_cnt
);

    localparam int unsigned FCNT_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [FCNT_W-1:0]   flush_cnt, flush_cnt_nxt;

    logic                accept_c;
    logic                is_ctrl_c;
    logic                cond_c;
    logic                taken_c;
    logic                mis_c;
    logic [WIDTH_PC-1:0] target_c;

    // Branch condition evaluation from funct3
    always_comb begin
        cond_c = 1'b0;
        case (funct3)
            3'b000:  cond_c = (rs1_data == rs2_data);
            3'b001:  cond_c = (rs1_data != rs2_data);
            3'b100:  cond_c = ($signed(rs1_data) <  $signed(rs2_data));
            3'b101:  cond_c = ($signed(rs1_data) >= $signed(rs2_data));
            3'b110:  cond_c = (rs1_data <  rs2_data);
            3'b111:  cond_c = (rs1_data >= rs2_data);
            default: cond_c = 1'b0;
        endcase
    end

    // Direction, target and acceptance of the EX instruction
    always_comb begin
        accept_c  = valid_ex & ~stall_ex & (state == IDLE);
        is_ctrl_c = is_branch | is_jal | is_jalr;
        taken_c   = is_jal | is_jalr | (is_branch & cond_c);
        mis_c     = taken_c ^ pred_taken;
        if (is_jalr) begin
            target_c = (rs1_data + imm) & ~WIDTH_PC'(1);
        end else if (taken_c) begin
            target_c = pc_ex + imm;
        end else begin
            target_c = pc_ex + WIDTH_PC'(4);
        end
    end

    // Flush window next-state: mispredict cycle is the first FLUSH cycle
    always_comb begin
        state_nxt     = state;
        flush_cnt_nxt = flush_cnt;
        case (state)
            IDLE: begin
                if (accept_c && mis_c) begin
                    state_nxt     = FLUSH;
                    flush_cnt_nxt = FCNT_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (flush_cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    flush_cnt_nxt = flush_cnt - FCNT_W'(1);
                end
            end
            default: begin
                state_nxt     = IDLE;
                flush_cnt_nxt = '0;
            end
        endcase
    end

    // State register and flush output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            flush_IF_ID <= 1'b0;
        end else begin
            state       <= state_nxt;
            flush_cnt   <= flush_cnt_nxt;
            flush_IF_ID <= (state_nxt == FLUSH);
        end
    end

    // Registered resolution outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCSel      <= 1'b0;
            branch_pc  <= '0;
            mispredict <= 1'b0;
        end else begin
            PCSel      <= accept_c & taken_c;
            mispredict <= accept_c & mis_c;
            if (accept_c) begin
                branch_pc <= target_c;
            end
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (accept_c && is_ctrl_c && (branch_cnt != '1)) begin
                branch_cnt <= branch_cnt + CNT_WIDTH'(1);
            end
            if (accept_c && mis_c && (mispred_cnt != '1)) begin
                mispred_cnt <= mispred_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed cases plus randomized
// traffic against a cycle-level behavioural model.
module tb_branch_resolve;

    localparam int unsigned FC = 2;

    logic        clk;
    logic        rst_n;
    logic        valid_ex, stall_ex;
    logic        is_branch, is_jal, is_jalr;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, pc_ex;
    logic        pred_taken;
    logic        PCSel;
    logic [31:0] branch_pc;
    logic        mispredict;
    logic        flush_IF_ID;
    logic [3:0]  branch_cnt, mispred_cnt;

    int checks;
    int errors;

    // model state
    int          flush_left;
    logic        m_pcsel;
    logic [31:0] m_pc;
    logic        m_mis;
    logic [3:0]  m_bcnt, m_mcnt;

    branch_resolve #(
        .WIDTH_PC    (32),
        .FLUSH_CYCLES(FC),
        .CNT_WIDTH   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_ex   (valid_ex),
        .stall_ex   (stall_ex),
        .is_branch  (is_branch),
        .is_jal     (is_jal),
        .is_jalr    (is_jalr),
        .funct3     (funct3),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm        (imm),
        .pc_ex      (pc_ex),
        .pred_taken (pred_taken),
        .PCSel      (PCSel),
        .branch_pc  (branch_pc),
        .mispredict (mispredict),
        .flush_IF_ID(flush_IF_ID),
        .branch_cnt (branch_cnt),
        .mispred_cnt(mispred_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        flush_left = 0;
        m_pcsel    = 1'b0;
        m_pc       = '0;
        m_mis      = 1'b0;
        m_bcnt     = '0;
        m_mcnt     = '0;
    endtask

    task automatic set_instr(input logic v, input logic s, input int kind,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] im,
                             input logic [31:0] pc, input logic pt);
        valid_ex   = v;
        stall_ex   = s;
        is_branch  = (kind == 1);
        is_jal     = (kind == 2);
        is_jalr    = (kind == 3);
        funct3     = f3;
        rs1_data   = a;
        rs2_data   = b;
        imm        = im;
        pc_ex      = pc;
        pred_taken = pt;
    endtask

    // Advance one clock: predict from current inputs, then compare all outputs
    task automatic step();
        bit          acc, tk, ctrl;
        logic [31:0] tgt;
        acc  = valid_ex && !stall_ex && (flush_left == 0);
        ctrl = is_branch || is_jal || is_jalr;
        if (acc) begin
            tk = 1'b0;
            if (is_jal || is_jalr) tk = 1'b1;
            else if (is_branch) begin
                case (funct3)
                    3'd0: tk = (rs1_data == rs2_data);
                    3'd1: tk = (rs1_data != rs2_data);
                    3'd4: tk = ($signed(rs1_data) <  $signed(rs2_data));
                    3'd5: tk = ($signed(rs1_data) >= $signed(rs2_data));
                    3'd6: tk = (rs1_data <  rs2_data);
                    3'd7: tk = (rs1_data >= rs2_data);
                    default: tk = 1'b0;
                endcase
            end
            if (is_jalr)  tgt = (rs1_data + imm) & 32'hFFFF_FFFE;
            else if (tk)  tgt = pc_ex + imm;
            else          tgt = pc_ex + 32'd4;
            m_pcsel = tk;
            m_pc    = tgt;
            m_mis   = (tk != pred_taken);
            if (ctrl && m_bcnt != 4'hF) m_bcnt = m_bcnt + 4'd1;
            if (m_mis && m_mcnt != 4'hF) m_mcnt = m_mcnt + 4'd1;
            if (m_mis) flush_left = FC;
        end else begin
            m_pcsel = 1'b0;
            m_mis   = 1'b0;
            if (flush_left > 0) flush_left--;
        end
        @(posedge clk);
        #1;
        check("pcsel",    32'(PCSel),       32'(m_pcsel));
        check("branch_pc", branch_pc,       m_pc);
        check("mispred",  32'(mispredict),  32'(m_mis));
        check("flush",    32'(flush_IF_ID), 32'(flush_left > 0));
        check("bcnt",     32'(branch_cnt),  32'(m_bcnt));
        check("mcnt",     32'(mispred_cnt), 32'(m_mcnt));
    endtask

    task automatic idle_cycles(input int n);
        set_instr(1'b0, 1'b0, 0, 3'd0, '0, '0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst_n = 1'b0;
        set_instr(1'b0, 1'b0, 0, 3'd0, '0, '0, '0, '0, 1'b0);
        #2;
        check("rst_pcsel", 32'(PCSel), 32'd0);
        check("rst_pc",    branch_pc,  32'd0);
        check("rst_flush", 32'(flush_IF_ID), 32'd0);
        check("rst_bcnt",  32'(branch_cnt),  32'd0);
        #10 rst_n = 1'b1;

        // beq taken, correctly predicted
        set_instr(1'b1, 1'b0, 1, 3'd0, 32'd5, 32'd5, 32'h20, 32'h100, 1'b1);
        step();
        check("beq_pcsel", 32'(PCSel), 32'd1);
        check("beq_pc",    branch_pc,  32'h120);
        check("beq_mis",   32'(mispredict), 32'd0);
        check("beq_bcnt",  32'(branch_cnt), 32'd1);

        // bltu not taken, predicted taken -> 2-cycle flush
        set_instr(1'b1, 1'b0, 1, 3'd6, 32'hFFFF_FFFF, 32'd1, 32'h40, 32'h200, 1'b1);
        step();
        check("bltu_pc",   branch_pc, 32'h204);
        check("bltu_mis",  32'(mispredict), 32'd1);
        check("bltu_fl0",  32'(flush_IF_ID), 32'd1);
        check("bltu_mcnt", 32'(mispred_cnt), 32'd1);
        idle_cycles(1);
        check("bltu_fl1",  32'(flush_IF_ID), 32'd1);
        idle_cycles(1);
        check("bltu_fl2",  32'(flush_IF_ID), 32'd0);

        // blt taken, predicted not taken; beqs during flush are squashed
        set_instr(1'b1, 1'b0, 1, 3'd4, 32'hFFFF_FFFF, 32'd1, 32'h10, 32'h300, 1'b0);
        step();
        check("blt_pcsel", 32'(PCSel), 32'd1);
        check("blt_mis",   32'(mispredict), 32'd1);
        set_instr(1'b1, 1'b0, 1, 3'd0, 32'd7, 32'd7, 32'h8, 32'h400, 1'b1);
        step();
        step();
        check("sq_bcnt",   32'(branch_cnt), 32'd3);
        check("sq_pcsel",  32'(PCSel), 32'd0);

        // jalr clears bit 0; stalled copy has no effect
        set_instr(1'b1, 1'b0, 3, 3'd0, 32'h1001, 32'd0, 32'h4, 32'h500, 1'b1);
        step();
        check("jalr_pc",   branch_pc, 32'h1004);
        check("jalr_pcsel", 32'(PCSel), 32'd1);
        set_instr(1'b1, 1'b1, 3, 3'd0, 32'h1001, 32'd0, 32'h4, 32'h500, 1'b1);
        step();
        check("stall_pcsel", 32'(PCSel), 32'd0);
        check("stall_bcnt",  32'(branch_cnt), 32'd4);

        // mispredict counter saturates at 0xF
        for (int k = 0; k < 17; k++) begin
            set_instr(1'b1, 1'b0, 0, 3'd0, '0, '0, '0, 32'(k * 8), 1'b1);
            step();
            idle_cycles(FC);
        end
        check("mcnt_sat", 32'(mispred_cnt), 32'hF);

        // reset in the first flush cycle aborts the flush asynchronously
        set_instr(1'b1, 1'b0, 0, 3'd0, '0, '0, '0, 32'h600, 1'b1);
        step();
        check("pre_rst_fl", 32'(flush_IF_ID), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_flush", 32'(flush_IF_ID), 32'd0);
        check("arst_mis",   32'(mispredict),  32'd0);
        check("arst_mcnt",  32'(mispred_cnt), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        set_instr(1'b1, 1'b0, 2, 3'd0, '0, '0, 32'h10, 32'h700, 1'b1);
        step();
        check("post_rst_pc", branch_pc, 32'h710);

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
            set_instr(($urandom_range(0, 9) < 8), ($urandom_range(0, 4) == 0),
                      int'($urandom_range(0, 3)), 3'($urandom), a, b,
                      $urandom, $urandom, 1'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
